mem_stage_lsu: RTL

- Memory-stage load/store unit. Consumes the EX/MEM pipeline register outputs (IR_M, ALU_out_M, RData2_M, MemToReg_M, MemWrite_M).
- Drives an external data memory over a req/gnt/rvalid handshake.
- Holds the pipeline with stall_M until the access completes, then presents aligned, extended load data to the MEM/WB register.
- Byte/half/word accesses and alignment checking are decoded here from the IR_M opcode.

---
 rtl/mem_stage_lsu_pkg.sv | 44 ++++
 rtl/mem_stage_lsu_if.sv | 26 ++
 rtl/mem_stage_lsu_lane_align.sv | 52 +++++
 rtl/mem_stage_lsu.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_lsu_pkg.sv
// Shared definitions for the memory-stage load/store unit.
//   - Opcode constants for the MIPS load/store instructions handled in M.
//   - FSM state encoding and access-size encoding.
//   - Decode helpers mapping an opcode to access size and signedness.
package mips_mem_pkg;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } lsu_size_e;

    // Unknown opcodes that still flag a memory access fall back to word size.
    function automatic lsu_size_e decode_size(input logic [5:0] op);
        lsu_size_e sz;
        case (op)
            OP_LB, OP_LBU, OP_SB: sz = SZ_B;
            OP_LH, OP_LHU, OP_SH: sz = SZ_H;
            default:              sz = SZ_W;
        endcase
        return sz;
    endfunction

    function automatic logic decode_signed(input logic [5:0] op);
        return (op == OP_LB) || (op == OP_LH);
    endfunction

endpackage

// File: rtl/mem_stage_lsu_if.sv
// Data-memory bus between the LSU (master) and the data memory (slave).
//   req/we/addr/be/wdata : request, driven by the LSU, held stable while req=1
//   gnt                  : memory accepted the request this cycle
//   rvalid/rdata         : read data return
interface mem_stage_lsu_if #(
    parameter int ADDR_W = 32
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [3:0]        be;
    logic [31:0]       wdata;
    logic              gnt;
    logic              rvalid;
    logic [31:0]       rdata;

    modport master (
        output req, we, addr, be, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, be, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/mem_stage_lsu_lane_align.sv
// Combinational byte-lane steering, shared by the store and load paths.
//   size, sgn  : access size and sign-extension flag
//   lane       : byte address bits [1:0] (little-endian)
//   st_data    : raw store data      -> be, wdata (replicated across lanes)
//   rd_data    : raw 32-bit read word -> ld_data (selected lane, extended)
//   misaligned : half on odd byte, or word not on a word boundary
module lsu_lane_align
    import mips_mem_pkg::*;
(
    input  lsu_size_e   size,
    input  logic        sgn,
    input  logic [1:0]  lane,
    input  logic [31:0] st_data,
    input  logic [31:0] rd_data,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] ld_data,
    output logic        misaligned
);
    logic [7:0]  rd_bytes [4];
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    for (genvar gi = 0; gi < 4; gi++) begin : g_bytes
        assign rd_bytes[gi] = rd_data[8*gi +: 8];
    end

    always_comb begin
        be         = 4'hF;
        wdata      = st_data;
        ld_data    = rd_data;
        misaligned = 1'b0;
        sel_byte   = rd_bytes[lane];
        sel_half   = lane[1] ? rd_data[31:16] : rd_data[15:0];
        case (size)
            SZ_B: begin
                be      = 4'b0001 << lane;
                wdata   = {4{st_data[7:0]}};
                ld_data = {{24{sgn & sel_byte[7]}}, sel_byte};
            end
            SZ_H: begin
                be         = 4'b0011 << {lane[1], 1'b0};
                wdata      = {2{st_data[15:0]}};
                ld_data    = {{16{sgn & sel_half[15]}}, sel_half};
                misaligned = lane[0];
            end
            default: begin
                misaligned = |lane;
            end
        endcase
    end
endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit.
//   clk, rst_n          : clock, asynchronous active-low reset
//   IR_M .. MemWrite_M  : EX/MEM pipeline register outputs
//   flush_M             : cancels the M-stage operation
//   dmem                : data-memory bus (master side)
//   stall_M             : holds IF..M while an access is outstanding
//   load_data_M/valid   : extended load result, valid for one cycle in DONE
//   addr_err_M          : misaligned access seen in IDLE (combinational)
//   bus_err_M           : gnt/rvalid timeout pulse
module mem_stage_lsu
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int MAX_WAIT = 255
)(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [31:0]     IR_M,
    input  logic [31:0]     ALU_out_M,
    input  logic [31:0]     RData2_M,
    input  logic            MemToReg_M,
    input  logic            MemWrite_M,
    input  logic            flush_M,
    mem_stage_lsu_if.master dmem,
    output logic            stall_M,
    output logic [31:0]     load_data_M,
    output logic            load_valid_M,
    output logic            addr_err_M,
    output logic            bus_err_M
);
    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    lsu_state_e        state_reg, state_next;
    logic [CNT_W-1:0]  wait_cnt_reg, wait_cnt_next;
    logic              discard_reg, discard_next;
    lsu_size_e         size_reg, size_next;
    logic              sgn_reg, sgn_next;
    logic [1:0]        lane_reg, lane_next;
    logic              req_reg, req_next;
    logic              we_reg, we_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [3:0]        be_reg, be_next;
    logic [31:0]       wdata_reg, wdata_next;
    logic [31:0]       load_data_reg, load_data_next;
    logic              load_valid_reg, load_valid_next;
    logic              bus_err_reg, bus_err_next;

    lsu_size_e   live_size, al_size;
    logic        live_sgn, al_sgn;
    logic [1:0]  al_lane;
    logic [3:0]  al_be;
    logic [31:0] al_wdata, al_ld;
    logic        al_misaligned;
    logic        access, mem_op, timeout;
    logic        unused_ir;

    assign unused_ir = ^IR_M[25:0];
    assign live_size = decode_size(IR_M[31:26]);
    assign live_sgn  = decode_signed(IR_M[31:26]);

    // In IDLE the aligner looks at the live instruction (store steering and
    // alignment check); once issued it uses the captured attributes so the
    // returning read data is extracted for the op that was actually sent.
    always_comb begin
        if (state_reg == IDLE) begin
            al_size = live_size;
            al_sgn  = live_sgn;
            al_lane = ALU_out_M[1:0];
        end else begin
            al_size = size_reg;
            al_sgn  = sgn_reg;
            al_lane = lane_reg;
        end
    end

    lsu_lane_align u_align (
        .size       (al_size),
        .sgn        (al_sgn),
        .lane       (al_lane),
        .st_data    (RData2_M),
        .rd_data    (dmem.rdata),
        .be         (al_be),
        .wdata      (al_wdata),
        .ld_data    (al_ld),
        .misaligned (al_misaligned)
    );

    assign access     = MemToReg_M | MemWrite_M;
    assign addr_err_M = rst_n & (state_reg == IDLE) & access & al_misaligned;
    assign mem_op     = access & ~flush_M & ~addr_err_M;
    assign timeout    = (wait_cnt_reg == CNT_W'(MAX_WAIT - 1));
    // REQ/WAIT stall regardless of flush; DONE releases for exactly one cycle.
    assign stall_M    = rst_n & ((state_reg == REQ) | (state_reg == WAIT) |
                                 (mem_op & (state_reg != DONE)));

    always_comb begin
        state_next      = state_reg;
        discard_next    = discard_reg;
        size_next       = size_reg;
        sgn_next        = sgn_reg;
        lane_next       = lane_reg;
        req_next        = req_reg;
        we_next         = we_reg;
        addr_next       = addr_reg;
        be_next         = be_reg;
        wdata_next      = wdata_reg;
        load_data_next  = load_data_reg;
        load_valid_next = 1'b0;
        bus_err_next    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (mem_op) begin
                    state_next   = REQ;
                    req_next     = 1'b1;
                    we_next      = MemWrite_M;
                    addr_next    = {ALU_out_M[ADDR_W-1:2], 2'b00};
                    be_next      = al_be;
                    wdata_next   = al_wdata;
                    size_next    = live_size;
                    sgn_next     = live_sgn;
                    lane_next    = ALU_out_M[1:0];
                    discard_next = 1'b0;
                end
            end
            REQ: begin
                if (dmem.gnt) begin
                    // A grant wins over a same-cycle flush: the access completes.
                    req_next     = 1'b0;
                    state_next   = we_reg ? DONE : WAIT;
                    discard_next = discard_reg | flush_M;
                end else if (flush_M) begin
                    req_next   = 1'b0;
                    state_next = IDLE;
                end else if (timeout) begin
                    req_next     = 1'b0;
                    bus_err_next = 1'b1;
                    state_next   = DONE;
                end
            end
            WAIT: begin
                if (dmem.rvalid) begin
                    if (discard_reg | flush_M) begin
                        state_next = IDLE;
                    end else begin
                        state_next      = DONE;
                        load_valid_next = 1'b1;
                        load_data_next  = al_ld;
                    end
                end else begin
                    discard_next = discard_reg | flush_M;
                    if (timeout) begin
                        bus_err_next = 1'b1;
                        state_next   = DONE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if ((state_next == state_reg) && ((state_reg == REQ) || (state_reg == WAIT))) begin
            wait_cnt_next = wait_cnt_reg + 1'b1;
        end else begin
            wait_cnt_next = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            wait_cnt_reg   <= '0;
            discard_reg    <= 1'b0;
            size_reg       <= SZ_B;
            sgn_reg        <= 1'b0;
            lane_reg       <= 2'b00;
            req_reg        <= 1'b0;
            we_reg         <= 1'b0;
            addr_reg       <= '0;
            be_reg         <= 4'h0;
            wdata_reg      <= 32'h0;
            load_data_reg  <= 32'h0;
            load_valid_reg <= 1'b0;
            bus_err_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            wait_cnt_reg   <= wait_cnt_next;
            discard_reg    <= discard_next;
            size_reg       <= size_next;
            sgn_reg        <= sgn_next;
            lane_reg       <= lane_next;
            req_reg        <= req_next;
            we_reg         <= we_next;
            addr_reg       <= addr_next;
            be_reg         <= be_next;
            wdata_reg      <= wdata_next;
            load_data_reg  <= load_data_next;
            load_valid_reg <= load_valid_next;
            bus_err_reg    <= bus_err_next;
        end
    end

    assign dmem.req     = req_reg;
    assign dmem.we      = we_reg;
    assign dmem.addr    = addr_reg;
    assign dmem.be      = be_reg;
    assign dmem.wdata   = wdata_reg;
    assign load_data_M  = load_data_reg;
    assign load_valid_M = load_valid_reg;
    assign bus_err_M    = bus_err_reg;
endmodule
